// File: rtl/iter_div.sv
// Radix-2 restoring integer divider (signed or unsigned) producing {quotient, remainder}.
// Latency: 34 cycles from accept to the next accept; result valid 33 cycles after the handshake cycle.
// Backpressure: both treadys low while busy; output is a one-cycle valid pulse with no ready.
module iter_div #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept, last_iter;
    logic [32:0] rem_q;
    logic [31:0] quo_q, dvsr_q;
    logic        q_neg, r_neg;
    logic [4:0]  cnt;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [33:0] shifted, trial;
    logic [32:0] rem_d;
    logic [31:0] quo_d, q_fix, r_fix;

    // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = SIGNED && s_axis_dividend_tdata[31];
        b_neg = SIGNED && s_axis_divisor_tdata[31];
        a_mag = a_neg ? (~s_axis_dividend_tdata + 32'd1) : s_axis_dividend_tdata;
        b_mag = b_neg ? (~s_axis_divisor_tdata + 32'd1) : s_axis_divisor_tdata;
    end

    // One restoring step: borrow out of the 34-bit trial means restore.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {2'b00, dvsr_q};
        rem_d   = trial[33] ? shifted[32:0] : trial[32:0];
        quo_d   = {quo_q[30:0], ~trial[33]};
        q_fix   = q_neg ? (~quo_d + 32'd1) : quo_d;
        r_fix   = r_neg ? (~rem_d[31:0] + 32'd1) : rem_d[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt              = state;
        s_axis_dividend_tready = 1'b0;
        s_axis_divisor_tready  = 1'b0;
        m_axis_dout_tvalid     = 1'b0;
        accept                 = 1'b0;
        last_iter              = 1'b0;
        case (state)
            IDLE: begin
                s_axis_dividend_tready = 1'b1;
                s_axis_divisor_tready  = 1'b1;
                accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                last_iter = (cnt == 5'd31);
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                m_axis_dout_tvalid = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q             <= '0;
            quo_q             <= '0;
            dvsr_q            <= '0;
            q_neg             <= 1'b0;
            r_neg             <= 1'b0;
            cnt               <= '0;
            m_axis_dout_tdata <= '0;
        end else if (accept) begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvsr_q <= b_mag;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            cnt    <= '0;
        end else if (state == CALC) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt   <= cnt + 5'd1;
            if (last_iter) begin
                m_axis_dout_tdata <= {q_fix, r_fix};
            end
        end
    end

endmodule

// File: doc/iter_div.md
# iter_div

Multi-cycle radix-2 restoring integer divider that acts as the responder on the divider stream interface driven by the execute stage for DIV/DIVU. It accepts one dividend/divisor pair through a valid/ready handshake and computes for 32 cycles. It then presents a one-cycle-valid 64-bit {quotient, remainder} result that the execute stage writes to LO/HI. Two instances replace the vendor dividers: SIGNED=1 for DIV, SIGNED=0 for DIVU.

## Interface
- SIGNED, default 1: 1 = two's-complement division, 0 = unsigned division.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_dividend_tdata  in  32  dividend.
- s_axis_dividend_tvalid  in  1  dividend present.
- s_axis_dividend_tready  out  1  block can accept the dividend.
- s_axis_divisor_tdata  in  32  divisor.
- s_axis_divisor_tvalid  in  1  divisor present.
- s_axis_divisor_tready  out  1  block can accept the divisor.
- m_axis_dout_tdata  out  64  {quotient[63:32], remainder[31:0]}; registered and held until the next result.
- m_axis_dout_tvalid  out  1  result valid, one-cycle pulse; there is no output ready, and the consumer must take the result in that cycle.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- Reset values: both tready = 1 (IDLE), m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0, iteration counter = 0.
- IDLE:
  - Both tready are driven 1 combinationally from the state.
  - Accept only when dividend_tvalid && divisor_tvalid in the same cycle. One valid alone is not accepted and produces no state change.
  - On accept:
    - Latch |dividend| and |divisor|, the quotient sign and the remainder sign.
    - Sign rules apply only when SIGNED=1; with SIGNED=0 the raw operands are used and both sign flags are 0.
    - Quotient sign = dividend[31] ^ divisor[31]. Remainder sign = dividend[31].
    - Clear the 33-bit partial remainder; load the quotient shift register with the dividend magnitude; counter = 0; go to CALC.
- CALC, one iteration per cycle:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep the difference and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - Counter increments each cycle. After iteration 32 (counter == 31), go to DONE.
  - Both tready = 0. Input data/valid changes are ignored because the operands are latched.
- DONE:
  - m_axis_dout_tvalid = 1 for exactly this cycle.
  - m_axis_dout_tdata = {sign-corrected quotient, sign-corrected remainder}; each is negated when its sign flag is set.
  - Both tready = 0. Next state is IDLE.
- Arithmetic rules:
  - Magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000.
  - Negation is 32-bit two's complement, so it wraps.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. No trap.
- Divide by zero gives the natural restoring result with no error flag: quotient magnitude 0xFFFFFFFF, remainder magnitude = |dividend|, then the sign correction above is applied.
- Upstream must deassert both tvalid after the handshake. Valids still high when the block returns to IDLE start a new division.
- Reset asserted in any state: next cycle is IDLE. The in-flight result is discarded, tvalid = 0 and tdata = 0.

## Timing
- Cycle 0: handshake, IDLE with both valids high.
- Cycles 1–32: CALC.
- Cycle 33: DONE, m_axis_dout_tvalid = 1.
- Cycle 34: IDLE, tready = 1; earliest next accept.
- Throughput is one division per 34 cycles.
- tready is a function of state only and never depends combinationally on tvalid.
- m_axis_dout_tdata changes only on the DONE-entry edge or on reset.

## Test plan
- Unsigned 100 / 7 (SIGNED=0), both valids high for cycle 0 only → cycle 33 tvalid = 1, tdata = {0x0000000E, 0x00000002}; tvalid = 0 at cycles 32 and 34.
- Signed 0xFFFFFFF9 / 2 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7 / 0xFFFFFFFE (7/−2) → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}. Unsigned 5 / 0 → {0xFFFFFFFF, 0x00000005}.
- Only dividend_tvalid high for 5 cycles → tready stays 1, no CALC, no tvalid. Divisor_tvalid then rises → accept on that cycle, result 33 cycles later.
- Reset pulsed at cycle 10 of a division → cycle 11: tready = 1, tvalid = 0, tdata = 0; no tvalid pulse appears at cycle 33.
- Both valids held high continuously with operands 9 and 3 → results at cycles 33 and 67, each {3, 0}; operand changes during CALC do not alter the result.
